// File: rtl/rom_dl_sequencer.sv
// rom_dl_sequencer: buffers ioctl ROM bytes into a small FIFO, latches SYSMODE/DIP bytes, sequences core reset
// Ports: clk_sys/reset_n clock and async active-low reset; user_reset sync reset request;
//        ioctl_* hps_io download port (ioctl_wait = backpressure); rom_wr_* / rom_addr / rom_data ROM write
//        handshake; sysmode/dsw config latches; core_reset to game core; loaded/overflow sticky status.
module rom_dl_sequencer #(
  parameter int FIFO_AW  = 2,
  parameter int HOLD_CYC = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        user_reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        rom_wr_req,
  input  logic        rom_wr_ack,
  output logic [24:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic [7:0]  sysmode,
  output logic [63:0] dsw,
  output logic        core_reset,
  output logic        loaded,
  output logic        overflow
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYC);
  typedef enum logic [1:0] {RUN, LOAD, DRAIN, HOLD} state_t;
  logic [32:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] count;
  logic dl_q, push_req, full, push, pop, rise, fall, dl_idx, set_loaded;
  state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  assign push_req   = ioctl_wr && ioctl_index == 8'd0;
  assign full       = count == (FIFO_AW+1)'(DEPTH);
  assign push       = push_req && !full;
  assign pop        = rom_wr_req && rom_wr_ack;
  assign rom_wr_req = count != '0;
  assign {rom_addr, rom_data} = mem[rd_ptr];
  assign rise       = ioctl_download && !dl_q;
  assign fall       = !ioctl_download && dl_q;
  assign dl_idx     = rise && (ioctl_index == 8'd0 || ioctl_index == 8'd1);
  assign core_reset = state != RUN;
  always_ff @(posedge clk_sys)
    if (push) mem[wr_ptr] <= {ioctl_addr, ioctl_dout};
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    set_loaded = 1'b0;
    case (state)
      RUN:
        if (dl_idx) state_n = LOAD;
        else if (user_reset) begin
          state_n = HOLD;
          cnt_n   = HOLD_INIT;
        end
      LOAD:
        if (fall) state_n = DRAIN;
      DRAIN:
        if (dl_idx) state_n = LOAD;
        else if (!rom_wr_req && !push) begin
          state_n    = HOLD;
          cnt_n      = HOLD_INIT;
          set_loaded = 1'b1;
        end
      HOLD:
        if (dl_idx) state_n = LOAD;
        else if (user_reset) cnt_n = HOLD_INIT;
        else if (cnt == 16'd1) state_n = RUN;
        else cnt_n = cnt - 16'd1;
      default: state_n = HOLD;
    endcase
  end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state      <= HOLD;
      cnt        <= HOLD_INIT;
      dl_q       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ioctl_wait <= 1'b0;
      sysmode    <= 8'h00;
      dsw        <= '1;
      loaded     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      dl_q       <= ioctl_download;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count      <= count + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
      // registered from the pre-push count so the byte arriving as wait rises still fits
      ioctl_wait <= count >= (FIFO_AW+1)'(DEPTH-1);
      if (ioctl_wr && ioctl_index == 8'd1 && ioctl_addr == 25'd0) sysmode <= ioctl_dout;
      if (ioctl_wr && ioctl_index == 8'hFE && ioctl_addr[24:3] == '0) dsw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
      if (set_loaded) loaded <= 1'b1;
      overflow   <= (overflow && !(state_n == LOAD && state != LOAD)) || (push_req && full);
    end
endmodule
